// File: rtl/mux_way16_bank_pkg.sv
// Shared constants for the registered 16-bit selector bank: default word width
// and the select widths of the 2-, 4- and 8-way selectors.
package mux_way16_bank_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam int SEL2_W = 1;
  localparam int SEL4_W = 2;
  localparam int SEL8_W = 3;

endpackage

// File: rtl/mux_way16_bank_tree.sv
// Combinational selector tree: 2-way leaf, 4-way from three leaves, and 8-way
// from two 4-way halves joined by a final leaf on the top select bit.

module mux16
  import mux_way16_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [SEL2_W-1:0] sel,
  output logic [WIDTH-1:0]  y
);

  // A known select routes only the chosen word, so an unknown on the other
  // input never reaches y.
  assign y = sel[0] ? b : a;

endmodule

module mux4way16
  import mux_way16_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  input  logic [WIDTH-1:0]  d,
  input  logic [SEL4_W-1:0] sel,
  output logic [WIDTH-1:0]  y
);

  logic [WIDTH-1:0] lo_w   [2];
  logic [WIDTH-1:0] hi_w   [2];
  logic [WIDTH-1:0] pair_w [2];

  assign lo_w[0] = a;
  assign hi_w[0] = b;
  assign lo_w[1] = c;
  assign hi_w[1] = d;

  // sel[0] chooses within {a,b} and {c,d}; sel[1] chooses between the pairs.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pair
    mux16 #(.WIDTH(WIDTH)) u_pair (
      .a   (lo_w[gi]),
      .b   (hi_w[gi]),
      .sel (sel[0]),
      .y   (pair_w[gi])
    );
  end

  mux16 #(.WIDTH(WIDTH)) u_final (
    .a   (pair_w[0]),
    .b   (pair_w[1]),
    .sel (sel[1]),
    .y   (y)
  );

endmodule

module mux8way16
  import mux_way16_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  input  logic [WIDTH-1:0]  d,
  input  logic [WIDTH-1:0]  e,
  input  logic [WIDTH-1:0]  f,
  input  logic [WIDTH-1:0]  g,
  input  logic [WIDTH-1:0]  h,
  input  logic [SEL8_W-1:0] sel,
  output logic [WIDTH-1:0]  y
);

  logic [WIDTH-1:0] src_w  [8];
  logic [WIDTH-1:0] half_w [2];

  assign src_w[0] = a;
  assign src_w[1] = b;
  assign src_w[2] = c;
  assign src_w[3] = d;
  assign src_w[4] = e;
  assign src_w[5] = f;
  assign src_w[6] = g;
  assign src_w[7] = h;

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    mux4way16 #(.WIDTH(WIDTH)) u_half (
      .a   (src_w[4*gi+0]),
      .b   (src_w[4*gi+1]),
      .c   (src_w[4*gi+2]),
      .d   (src_w[4*gi+3]),
      .sel (sel[1:0]),
      .y   (half_w[gi])
    );
  end

  mux16 #(.WIDTH(WIDTH)) u_final (
    .a   (half_w[0]),
    .b   (half_w[1]),
    .sel (sel[2]),
    .y   (y)
  );

endmodule

// File: rtl/mux_way16_bank.sv
// Registered selector bank: 2-, 4- and 8-way word selectors on one shared
// select bus, each followed by a single output register with sync reset.
module mux_way16_bank
  import mux_way16_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  input  logic [WIDTH-1:0]  d,
  input  logic [WIDTH-1:0]  e,
  input  logic [WIDTH-1:0]  f,
  input  logic [WIDTH-1:0]  g,
  input  logic [WIDTH-1:0]  h,
  input  logic [SEL8_W-1:0] sel,
  output logic [WIDTH-1:0]  mux,
  output logic [WIDTH-1:0]  mux4,
  output logic [WIDTH-1:0]  mux8
);

  logic [WIDTH-1:0] mux_w, mux4_w, mux8_w;
  logic [WIDTH-1:0] mux_d, mux4_d, mux8_d;
  logic [WIDTH-1:0] mux_q, mux4_q, mux8_q;

  mux16 #(.WIDTH(WIDTH)) u_mux2 (
    .a   (a),
    .b   (b),
    .sel (sel[SEL2_W-1:0]),
    .y   (mux_w)
  );

  mux4way16 #(.WIDTH(WIDTH)) u_mux4 (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel[SEL4_W-1:0]),
    .y   (mux4_w)
  );

  mux8way16 #(.WIDTH(WIDTH)) u_mux8 (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .sel (sel),
    .y   (mux8_w)
  );

  always_comb begin
    mux_d  = mux_w;
    mux4_d = mux4_w;
    mux8_d = mux8_w;
  end

  // Reset overrides whatever selection is in flight on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_q  <= '0;
      mux4_q <= '0;
      mux8_q <= '0;
    end else begin
      mux_q  <= mux_d;
      mux4_q <= mux4_d;
      mux8_q <= mux8_d;
    end
  end

  assign mux  = mux_q;
  assign mux4 = mux4_q;
  assign mux8 = mux8_q;

endmodule

// File: tb/tb_mux_way16_bank.sv
// Self-checking bench for mux_way16_bank: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_mux_way16_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [2:0]  sel;
  logic [15:0] mux, mux4, mux8;

  logic [15:0] exp_mux, exp_mux4, exp_mux8;
  logic        model_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_way16_bank #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .e    (e),
    .f    (f),
    .g    (g),
    .h    (h),
    .sel  (sel),
    .mux  (mux),
    .mux4 (mux4),
    .mux8 (mux8)
  );

  // Source number idx in 0..7 names inputs a..h in order.
  function automatic logic [15:0] pick(input int idx);
    case (idx)
      0:       return a;
      1:       return b;
      2:       return c;
      3:       return d;
      4:       return e;
      5:       return f;
      6:       return g;
      default: return h;
    endcase
  endfunction

  // Reference: what each output must hold after this edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_mux  <= 16'h0000;
      exp_mux4 <= 16'h0000;
      exp_mux8 <= 16'h0000;
    end else begin
      exp_mux  <= pick(int'(sel) % 2);
      exp_mux4 <= pick(int'(sel) % 4);
      exp_mux8 <= pick(int'(sel));
    end
    model_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_mux",  mux,  exp_mux);
      check("model_mux4", mux4, exp_mux4);
      check("model_mux8", mux8, exp_mux8);
      $display("cycle t=%0t rst=%0b sel=%0d mux=%h mux4=%h mux8=%h", $time, rst, sel, mux, mux4, mux8);
    end
  end

  task automatic load_ramp();
    a = 16'h0000; b = 16'h0001; c = 16'h0002; d = 16'h0003;
    e = 16'h0004; f = 16'h0005; g = 16'h0006; h = 16'h0007;
  endtask

  initial begin
    rst = 1'b1;
    sel = 3'd5;
    load_ramp();

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mux",  mux,  16'h0000);
    check("reset_mux4", mux4, 16'h0000);
    check("reset_mux8", mux8, 16'h0000);

    // Sweep sel 0..7 with a ramp of source values.
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      @(negedge clk);
      if (s == 0) begin
        check("sweep0_mux",  mux,  16'h0000);
        check("sweep0_mux4", mux4, 16'h0000);
        check("sweep0_mux8", mux8, 16'h0000);
      end
      if (s == 3) begin
        check("sweep3_mux",  mux,  16'h0001);
        check("sweep3_mux4", mux4, 16'h0003);
        check("sweep3_mux8", mux8, 16'h0003);
      end
      if (s == 6) begin
        check("sweep6_mux",  mux,  16'h0000);
        check("sweep6_mux4", mux4, 16'h0002);
        check("sweep6_mux8", mux8, 16'h0006);
      end
      if (s == 7) begin
        check("sweep7_mux",  mux,  16'h0001);
        check("sweep7_mux4", mux4, 16'h0003);
        check("sweep7_mux8", mux8, 16'h0007);
      end
    end

    // Wrap 7 -> 0.
    sel = 3'd0;
    @(negedge clk);
    check("wrap_mux8", mux8, 16'h0000);

    // Full-width data patterns.
    a = 16'hFFFF; b = 16'hA5A5; h = 16'h8001;
    sel = 3'd0;
    @(negedge clk);
    check("full_sel0_mux", mux, 16'hFFFF);
    sel = 3'd1;
    @(negedge clk);
    check("full_sel1_mux", mux, 16'hA5A5);
    sel = 3'd7;
    @(negedge clk);
    check("full_sel7_mux8", mux8, 16'h8001);
    check("full_sel7_mux",  mux,  16'hA5A5);

    // Mid-stream reset at sel=4.
    load_ramp();
    sel = 3'd3;
    @(negedge clk);
    sel = 3'd4;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mux",  mux,  16'h0000);
    check("midrst_mux4", mux4, 16'h0000);
    check("midrst_mux8", mux8, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("resume_mux8", mux8, 16'h0004);

    // Unselected upper sources driven unknown.
    sel = 3'd2;
    e = 16'hxxxx; f = 16'hxxxx; g = 16'hxxxx; h = 16'hxxxx;
    @(negedge clk);
    check("iso_mux4", mux4, 16'h0002);
    check("iso_mux8", mux8, 16'h0002);
    check("iso_mux",  mux,  16'h0000);
    check("iso_known", {15'd0, $isunknown({mux, mux4, mux8})}, 16'h0000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      e = 16'($urandom); f = 16'($urandom); g = 16'($urandom); h = 16'($urandom);
      sel = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_way16_bank.md
# mux_way16_bank

Registered 16-bit selector bank providing 2-way, 4-way and 8-way word multiplexers that share one select bus. It sits in the ALU/datapath layer, where it selects 16-bit operands from up to eight sources. The combinational mux tree is followed by one output register stage on the single system clock.

## Interface
Parameters:
- WIDTH, 16, word width of every data input and output (the bench uses 16 only).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  source 0.
- b  input  WIDTH  source 1.
- c  input  WIDTH  source 2.
- d  input  WIDTH  source 3.
- e  input  WIDTH  source 4.
- f  input  WIDTH  source 5.
- g  input  WIDTH  source 6.
- h  input  WIDTH  source 7.
- sel  input  3  shared select.
- mux  output  WIDTH  registered 2-way result.
- mux4  output  WIDTH  registered 4-way result.
- mux8  output  WIDTH  registered 8-way result.

## Operation
- 2-way: mux_next = sel[0] ? b : a. sel[2:1] is ignored.
- 4-way: mux4_next = {a,b,c,d}[sel[1:0]], with 0→a, 1→b, 2→c, 3→d. sel[2] is ignored.
- 8-way: mux8_next = {a..h}[sel], with 0→a … 7→h.
- All three results are computed from the same sel value in the same cycle.
- Selection is bitwise and lossless: no arithmetic, no sign handling, no width change.
- sel wraps naturally as a 3-bit value: 7 followed by 0 selects h, then a.
- X/Z on an unselected input does not propagate to the outputs.

## Timing
- Latency is 1 cycle. Inputs and sel sampled at rising edge N appear on mux/mux4/mux8 after edge N.
- Throughput is one new selection per cycle, with no handshake and no stall.
- Reset: if rst=1 at a rising edge, mux, mux4 and mux8 all become 0 after that edge, regardless of the data inputs. Reset wins over any simultaneous data or select change.
- After rst deasserts, the first edge with rst=0 loads normal results.
- Reset asserted mid-stream discards the in-flight selection; nothing is retained.
- Between edges the outputs are stable. Input glitches are not visible on the outputs.

## Structure
- Shared package: the WIDTH default constant and the select-width constants (SEL2_W=1, SEL4_W=2, SEL8_W=3).
- Natural sub-modules, composed hierarchically:
  - mux16: 2-way WIDTH-bit selector, purely combinational.
  - mux4way16: built from three mux16 instances. sel[0] picks within {a,b} and {c,d}; sel[1] picks between the two pairs.
  - mux8way16: built from two mux4way16 instances (a–d and e–h) plus one mux16 on sel[2].
- Top level: instantiates one mux16, one mux4way16 and one mux8way16 on shared inputs, then registers the three results under clk/rst.

## Test plan
- Reset: drive a..h = 0x0000..0x0007 and sel=5, and hold rst=1 for 2 edges. Then mux=mux4=mux8=0x0000.
- Sweep: with rst=0, step sel 0→7, one value per cycle. The outputs lag sel by one cycle:
  - sel=0: mux=0, mux4=0, mux8=0.
  - sel=3: mux=1, mux4=3, mux8=3.
  - sel=6: mux=0, mux4=2, mux8=6.
  - sel=7: mux=1, mux4=3, mux8=7.
- Wrap: step sel from 7 to 0. Next cycle mux8 goes from 0x0007 to 0x0000.
- Full-width data: set a=0xFFFF, b=0xA5A5, h=0x8001.
  - sel=0: mux=0xFFFF.
  - sel=1: mux=0xA5A5.
  - sel=7: mux8=0x8001 and mux=0xA5A5.
- Mid-stream reset: during a sweep at sel=4, assert rst for one edge. Outputs go to 0 for that cycle, then resume with mux8=0x0004 one cycle after rst drops while sel=4 is still applied.
- Isolation: set sel=2 and drive e..h to X. Then mux4=c and mux8=c, with no X on any output.
